// File: rtl/sifh_hist_engine_pkg.sv
// Shared definitions for the SIFH histogram engine: FSM encoding, default
// parameter values and the saturating bin-counter increment.
package sifh_hist_engine_pkg;

   localparam int NP_DEF      = 10;
   localparam int BIN_W_DEF   = 6;
   localparam int PIX_NUM_DEF = 4;
   localparam int CNT_W_DEF   = 8;
   localparam int ACQ_NUM_DEF = 2;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ACCUM,
      DRAIN,
      SCAN
   } state_t;

   // Increment that sticks at the all-ones value of a width-bit counter.
   function automatic logic [31:0] satInc(input logic [31:0] val, input int width);
      logic [31:0] maxVal;
      maxVal = (32'd1 << width) - 32'd1;
      return (val >= maxVal) ? maxVal : val + 32'd1;
   endfunction

endpackage

// File: rtl/sifh_peak_tracker.sv
// Running maximum over one pixel's bins; restarts when bin 0 arrives.
// Peak result registered one cycle after the last bin; no backpressure, holds until the next peak.
module sifh_peak_tracker #(
   parameter int PIX_W = 2,
   parameter int BIN_W = 6,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             res,
   input  logic             dataVld,
   input  logic [PIX_W-1:0] dataPix,
   input  logic [BIN_W-1:0] dataBin,
   input  logic [CNT_W-1:0] dataCnt,
   output logic             peakVld,
   output logic [PIX_W-1:0] peakPix,
   output logic [BIN_W-1:0] peakBin,
   output logic [CNT_W-1:0] peakCnt
);

   logic [BIN_W-1:0] bestBin;
   logic [CNT_W-1:0] bestCnt;
   logic [BIN_W-1:0] nextBin;
   logic [CNT_W-1:0] nextCnt;
   logic             firstBin;
   logic             lastBin;
   logic             take;

   // Strictly-greater compare, so on a tie the earlier (lower) bin is kept.
   assign firstBin = (dataBin == '0);
   assign lastBin  = (dataBin == '1);
   assign take     = firstBin | (dataCnt > bestCnt);
   assign nextBin  = take ? dataBin : bestBin;
   assign nextCnt  = take ? dataCnt : bestCnt;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         bestBin <= '0;
         bestCnt <= '0;
         peakVld <= 1'b0;
         peakPix <= '0;
         peakBin <= '0;
         peakCnt <= '0;
      end else begin
         peakVld <= 1'b0;
         if (dataVld) begin
            bestBin <= nextBin;
            bestCnt <= nextCnt;
            if (lastBin) begin
               peakVld <= 1'b1;
               peakPix <= dataPix;
               peakBin <= nextBin;
               peakCnt <= nextCnt;
            end
         end
      end
   end

endmodule

// File: rtl/sifh_hist_engine.sv
// Per-pixel timestamp histogram: clear, accumulate ACQ_NUM acquisitions, then clear-on-read peak scan.
// One sample/cycle read-modify-write (write one cycle after read); in_ready high only while accumulating.
module sifh_hist_engine
   import sifh_hist_engine_pkg::*;
#(
   parameter int NP       = NP_DEF,
   parameter int BIN_W    = BIN_W_DEF,
   parameter int PIX_NUM  = PIX_NUM_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int ACQ_NUM  = ACQ_NUM_DEF,
   localparam int PIX_W   = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1,
   localparam int ADDR_W  = PIX_W + BIN_W
) (
   input  logic              clk,
   input  logic              res,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PIX_W-1:0]  in_pix,
   input  logic [NP-1:0]     in_ts,
   input  logic              acq_end,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [CNT_W-1:0]  mem_rdata,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [CNT_W-1:0]  mem_wdata,
   output logic              peak_valid,
   output logic [PIX_W-1:0]  peak_pix,
   output logic [BIN_W-1:0]  peak_bin,
   output logic [CNT_W-1:0]  peak_count,
   output logic              busy,
   output logic              done
);

   localparam int DEPTH = PIX_NUM << BIN_W;
   localparam int ACQ_W = $clog2(ACQ_NUM) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ACQ_W-1:0]  LAST_ACQ  = ACQ_W'(ACQ_NUM - 1);
   localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(PIX_NUM - 1);

   state_t            state;
   logic [ADDR_W-1:0] addrCnt;
   logic              scanRdDone;
   logic [ACQ_W-1:0]  acqCnt;
   logic              p1Vld;
   logic [ADDR_W-1:0] p1Addr;
   logic              s1Vld;
   logic [ADDR_W-1:0] s1Addr;
   logic              lastWen;
   logic [ADDR_W-1:0] lastWaddr;
   logic [CNT_W-1:0]  lastWdata;

   logic              accept;
   logic              pixOk;
   logic              sampleRd;
   logic              scanRd;
   logic [ADDR_W-1:0] sampleAddr;
   logic [CNT_W-1:0]  oldCnt;
   logic              unusedTsBits;

   assign in_ready = (state == ACCUM);
   assign busy     = (state != IDLE);

   assign accept       = in_valid & in_ready;
   assign pixOk        = ({1'b0, in_pix} < (PIX_W + 1)'(PIX_NUM));
   assign sampleRd     = accept & pixOk;
   assign sampleAddr   = {in_pix, in_ts[NP-1 -: BIN_W]};
   assign unusedTsBits = ^in_ts;
   assign scanRd       = (state == SCAN) & ~scanRdDone;

   assign mem_ren   = sampleRd | scanRd;
   assign mem_raddr = scanRd ? addrCnt : (sampleRd ? sampleAddr : '0);

   // The RAM returns pre-write data when a read meets a write to the same
   // address, so the previous cycle's write is the up-to-date value.
   assign oldCnt = (lastWen && lastWaddr == p1Addr) ? lastWdata : mem_rdata;

   always_comb begin
      mem_wen   = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (state == CLEAR) begin
         mem_wen   = 1'b1;
         mem_waddr = addrCnt;
      end else if (p1Vld) begin
         mem_wen   = 1'b1;
         mem_waddr = p1Addr;
         mem_wdata = CNT_W'(satInc(32'(oldCnt), CNT_W));
      end else if (s1Vld) begin
         mem_wen   = 1'b1;
         mem_waddr = s1Addr;
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state      <= IDLE;
         addrCnt    <= '0;
         scanRdDone <= 1'b0;
         acqCnt     <= '0;
         p1Vld      <= 1'b0;
         p1Addr     <= '0;
         s1Vld      <= 1'b0;
         s1Addr     <= '0;
         lastWen    <= 1'b0;
         lastWaddr  <= '0;
         lastWdata  <= '0;
         done       <= 1'b0;
      end else begin
         done      <= 1'b0;
         lastWen   <= mem_wen;
         lastWaddr <= mem_waddr;
         lastWdata <= mem_wdata;
         p1Vld     <= sampleRd;
         p1Addr    <= sampleAddr;
         s1Vld     <= scanRd;
         s1Addr    <= addrCnt;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= CLEAR;
                  addrCnt <= '0;
                  acqCnt  <= '0;
               end
            end
            CLEAR: begin
               if (addrCnt == LAST_ADDR) begin
                  state   <= ACCUM;
                  addrCnt <= '0;
               end else begin
                  addrCnt <= addrCnt + ADDR_W'(1);
               end
            end
            ACCUM: begin
               if (acq_end) begin
                  if (acqCnt == LAST_ACQ) begin
                     state  <= DRAIN;
                     acqCnt <= '0;
                  end else begin
                     acqCnt <= acqCnt + ACQ_W'(1);
                  end
               end
            end
            DRAIN: begin
               state      <= SCAN;
               addrCnt    <= '0;
               scanRdDone <= 1'b0;
            end
            SCAN: begin
               if (!scanRdDone) begin
                  if (addrCnt == LAST_ADDR) begin
                     scanRdDone <= 1'b1;
                  end else begin
                     addrCnt <= addrCnt + ADDR_W'(1);
                  end
               end
               if (peak_valid && peak_pix == LAST_PIX) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   sifh_peak_tracker #(
      .PIX_W (PIX_W),
      .BIN_W (BIN_W),
      .CNT_W (CNT_W)
   ) peakTracker (
      .clk     (clk),
      .res     (res),
      .dataVld (s1Vld),
      .dataPix (s1Addr[ADDR_W-1 -: PIX_W]),
      .dataBin (s1Addr[BIN_W-1:0]),
      .dataCnt (mem_rdata),
      .peakVld (peak_valid),
      .peakPix (peak_pix),
      .peakBin (peak_bin),
      .peakCnt (peak_count)
   );

endmodule

// File: doc/sifh_hist_engine.md
SIFH_HIST_ENGINE -- requirements
Module: sifh_hist_engine

Interface
REQ-001 Parameter NP, 10, timestamp width in bits.
REQ-002 Parameter BIN_W, 6, histogram bin index width; bin = in_ts[NP-1 -: BIN_W]; BIN_W <= NP.
REQ-003 Parameter PIX_NUM, 4, pixel channels; PIX_W = max(1, clog2(PIX_NUM)).
REQ-004 Parameter CNT_W, 8, bin counter width.
REQ-005 Parameter ACQ_NUM, 2, acquisitions accumulated per histogram.
REQ-006 Ports: one clock and one reset, listed first; reset is asynchronous and active-low.
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 res  in  1  asynchronous active-low reset.
REQ-009 start  in  1  one-cycle pulse, begins clear + accumulate cycle.
REQ-010 in_valid / in_ready  in / out  1 / 1  timestamp handshake; transfer when both high.
REQ-011 in_pix  in  PIX_W  pixel of sample; in_ts  in  NP  timestamp.
REQ-012 acq_end  in  1  pulse, closes current acquisition.
REQ-013 mem_ren  out  1; mem_raddr  out  PIX_W+BIN_W; mem_rdata  in  CNT_W  (rdata valid one cycle after mem_ren).
REQ-014 mem_wen  out  1; mem_waddr  out  PIX_W+BIN_W; mem_wdata  out  CNT_W.
REQ-015 peak_valid  out  1; peak_pix  out  PIX_W; peak_bin  out  BIN_W; peak_count  out  CNT_W.
REQ-016 busy  out  1 (state != IDLE); done  out  1 (one-cycle pulse at end of scan).

Function
REQ-017 Address = {pix, bin}; memory depth PIX_NUM*2^BIN_W.
REQ-018 FSM states IDLE, CLEAR, ACCUM, DRAIN, SCAN; start honoured only in IDLE.
REQ-019 IDLE --start--> CLEAR: write 0 to addresses 0..depth-1 ascending, one per cycle, then ACCUM.
REQ-020 in_ready = 1 only in ACCUM; samples with in_pix >= PIX_NUM are accepted and dropped (no memory access).
REQ-021 Accepted sample at cycle t: mem_ren=1 at t; at t+1 mem_wen=1, same address, mem_wdata = old+1, saturating at 2^CNT_W-1.
REQ-022 Throughput one sample/cycle; back-to-back same address: old value taken from the write being issued in that cycle (forward), not mem_rdata.
REQ-023 acq_end in ACCUM increments acquisition counter; sample accepted in same cycle belongs to closing acquisition.
REQ-024 acq_end closing acquisition ACQ_NUM: in_ready drops next cycle; DRAIN one cycle for last write; then SCAN.
REQ-025 acq_end outside ACCUM ignored.
REQ-026 SCAN: per pixel, read bins 0..2^BIN_W-1 ascending, one per cycle; write 0 to each bin one cycle after its read (clear-on-read).
REQ-027 Peak = strictly greater compare; ties keep lowest bin; all-zero pixel reports bin 0, count 0.
REQ-028 One cycle after last bin data of a pixel returns: peak_valid=1 one cycle with peak_pix/bin/count; outputs hold until next peak_valid.
REQ-029 After last pixel's peak: done=1 one cycle, state IDLE.

Reset
REQ-030 res low: state IDLE, all counters/pipeline regs 0, every output 0 (in_ready, mem_ren, mem_wen, peak_*, busy, done).
REQ-031 Reset mid-operation aborts without completing pending write; memory content undefined until next CLEAR.

Structure
REQ-032 Shared package: FSM state encoding, default parameter values, saturating-increment function.
REQ-033 One sub-module natural: sifh_peak_tracker (running max, bin index, reset per pixel).

Verification
REQ-034 PIX_NUM=2, BIN_W=3, NP=6, ACQ_NUM=2: start -> 16 clear writes of 0, then in_ready=1.
REQ-035 Ts 0b101000 pixel 1 three times back-to-back -> writes 1,2,3 to address 13; final count 3.
REQ-036 CNT_W=2: five hits one bin -> counts 1,2,3,3,3.
REQ-037 Pixel 0 bins 2 and 5 each 4 hits across two acquisitions -> peak_pix 0, bin 2, count 4; pixel 1 empty -> bin 0, count 0; done then busy=0.
REQ-038 Sample with acq_end on second acquisition accepted and counted; in_ready=0 next cycle.
REQ-039 res low during ACCUM -> all outputs 0 immediately; new start clears and yields correct peaks.
